uxrom_ext_mapper: RTL and testbench

- Parametrised UxROM-class mapper for the cartridge CPLD.
- Adds a wider switchable PRG bank, CHR-RAM banking, selectable mirroring (including software one-screen) and a programmable CPU-cycle IRQ counter.
- Runs on a free-running system clock; M2 is synchronised and edge-detected internally, so all register writes are synchronous state updates.
- Sits between the cartridge edge (CPU/PPU buses) and the PRG flash, CHR SRAM and CIRAM control pins.

---
 rtl/mapper_pkg.sv | 22 ++
 rtl/cpu_cycle_irq.sv | 71 +++++++
 rtl/uxrom_ext_mapper.sv | 188 ++++++++++++++++++
 tb/tb_uxrom_ext_mapper.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mapper_pkg.sv
// Shared constants for the UxROM-class extended mapper.
//   MIRROR_*        : values of the MIRROR_MODE parameter
//   irq_reg_e       : register offsets (A1..A0) inside the $5000 IRQ page
//   IRQ_PAGE        : A14..A12 pattern that selects the IRQ page
//   FIXED_PRG_BANK  : flash A18..A14 driven for the $C000-$FFFF window
package mapper_pkg;

  localparam int MIRROR_H   = 0;
  localparam int MIRROR_V   = 1;
  localparam int MIRROR_ONE = 2;

  typedef enum logic [1:0] {
    IRQ_RELOAD_LO = 2'd0,
    IRQ_RELOAD_HI = 2'd1,
    IRQ_CTRL      = 2'd2,
    IRQ_ACK       = 2'd3
  } irq_reg_e;

  localparam logic [2:0] IRQ_PAGE       = 3'b101;
  localparam logic [4:0] FIXED_PRG_BANK = 5'b11111;

endpackage

// File: rtl/cpu_cycle_irq.sv
// Programmable CPU-cycle IRQ counter.
// Ports:
//   clk, rst_n  : system clock, synchronous active-low reset
//   tick        : one-clk pulse per CPU cycle (synchronised M2 falling edge)
//   wr_en       : register write commit (only ever asserted together with tick)
//   wr_offset   : register offset within the IRQ page
//   wr_data     : write data
//   pending     : IRQ pending flag
module cpu_cycle_irq
  import mapper_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       wr_en,
  input  logic [1:0] wr_offset,
  input  logic [7:0] wr_data,
  output logic       pending
);

  logic [15:0] reload_reg;
  logic [15:0] counter_reg;
  logic        enable_reg;
  logic        auto_reload_reg;
  logic        pending_reg;
  logic        ctrl_wr;

  // A control write reloads the counter on the same tick, so that tick must
  // not also count.
  assign ctrl_wr = wr_en && (irq_reg_e'(wr_offset) == IRQ_CTRL);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reload_reg      <= 16'h0000;
      counter_reg     <= 16'h0000;
      enable_reg      <= 1'b0;
      auto_reload_reg <= 1'b0;
      pending_reg     <= 1'b0;
    end else begin
      if (wr_en) begin
        case (irq_reg_e'(wr_offset))
          IRQ_RELOAD_LO: reload_reg[7:0]  <= wr_data;
          IRQ_RELOAD_HI: reload_reg[15:8] <= wr_data;
          IRQ_CTRL: begin
            enable_reg      <= wr_data[0];
            auto_reload_reg <= wr_data[1];
            counter_reg     <= reload_reg;
          end
          IRQ_ACK:       pending_reg <= 1'b0;
          default:       ;
        endcase
      end
      // Placed after the acknowledge so an expiry on the same tick wins.
      if (tick && enable_reg && !ctrl_wr) begin
        if (counter_reg == 16'h0000) begin
          pending_reg <= 1'b1;
          if (auto_reload_reg) begin
            counter_reg <= reload_reg;
          end else begin
            enable_reg <= 1'b0;
          end
        end else begin
          counter_reg <= counter_reg - 16'h0001;
        end
      end
    end
  end

  assign pending = pending_reg;

endmodule

// File: rtl/uxrom_ext_mapper.sv
// UxROM-class cartridge mapper with wide PRG banking, CHR-RAM banking,
// selectable mirroring and a CPU-cycle IRQ counter.
// Ports:
//   clk, rst_n            : system clock (>= 8x M2), synchronous active-low reset
//   m2                    : CPU M2, asynchronous, synchronised internally
//   romsel, cpu_rw_in     : /ROMSEL (active low), CPU R/W (0 = write)
//   cpu_addr_in/data_in   : CPU A14..A0, D7..D0
//   cpu_addr_out          : flash A18..A12
//   cpu_wr_out/rd_out/flash_ce/sram_ce : PRG-side strobes, active low
//   ppu_rd_in, ppu_wr_in  : PPU /RD, /WR
//   ppu_addr_in           : PPU A13..A10
//   ppu_addr_out          : CHR A18..A10
//   ppu_rd_out/wr_out/flash_ce/sram_ce/ciram_a10/ciram_ce : CHR and CIRAM control
//   irq                   : open-drain /IRQ (0 or z)
//   led                   : low while an IRQ is pending
module uxrom_ext_mapper
  import mapper_pkg::*;
#(
  parameter int PRG_BANK_BITS = 4,
  parameter int CHR_BANK_BITS = 0,
  parameter int MIRROR_MODE   = 0,
  parameter int IRQ_ENABLE    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m2,
  input  logic        romsel,
  input  logic        cpu_rw_in,
  input  logic [14:0] cpu_addr_in,
  input  logic [7:0]  cpu_data_in,
  output logic [6:0]  cpu_addr_out,
  output logic        cpu_wr_out,
  output logic        cpu_rd_out,
  output logic        cpu_flash_ce,
  output logic        cpu_sram_ce,
  input  logic        ppu_rd_in,
  input  logic        ppu_wr_in,
  input  logic [3:0]  ppu_addr_in,
  output logic [8:0]  ppu_addr_out,
  output logic        ppu_rd_out,
  output logic        ppu_wr_out,
  output logic        ppu_flash_ce,
  output logic        ppu_sram_ce,
  output logic        ppu_ciram_a10,
  output logic        ppu_ciram_ce,
  output logic        irq,
  output logic        led
);

  // ---------------------------------------------------------------- M2 sync
  logic m2_s1_reg, m2_s2_reg, m2_hist_reg;
  logic m2_fall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m2_s1_reg   <= 1'b0;
      m2_s2_reg   <= 1'b0;
      m2_hist_reg <= 1'b0;
    end else begin
      m2_s1_reg   <= m2;
      m2_s2_reg   <= m2_s1_reg;
      m2_hist_reg <= m2_s2_reg;
    end
  end

  assign m2_fall = m2_hist_reg & ~m2_s2_reg;

  // ---------------------------------------------------------- bus capture
  // Keeps following the bus while M2 is high; the last sample taken before
  // the synchronised fall is what the commit uses.
  logic       cap_rw_reg;
  logic       cap_romsel_reg;
  logic [2:0] cap_addr_hi_reg;
  logic [1:0] cap_off_reg;
  logic [7:0] cap_data_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_rw_reg      <= 1'b1;
      cap_romsel_reg  <= 1'b1;
      cap_addr_hi_reg <= 3'b000;
      cap_off_reg     <= 2'b00;
      cap_data_reg    <= 8'h00;
    end else if (m2_s2_reg) begin
      cap_rw_reg      <= cpu_rw_in;
      cap_romsel_reg  <= romsel;
      cap_addr_hi_reg <= cpu_addr_in[14:12];
      cap_off_reg     <= cpu_addr_in[1:0];
      cap_data_reg    <= cpu_data_in;
    end
  end

  logic commit, bank_wr, irq_wr;

  assign commit  = m2_fall & ~cap_rw_reg;
  assign bank_wr = commit & ~cap_romsel_reg;
  assign irq_wr  = commit & cap_romsel_reg & (cap_addr_hi_reg == IRQ_PAGE);

  // --------------------------------------------------------- bank register
  // Bank numbers are held at full width with the unused high bits tied to
  // zero, which gives the zero-extension on the address outputs for free.
  logic [4:0] prg_bank_reg, prg_bank_next;
  logic [1:0] chr_bank_reg, chr_bank_next;
  logic       one_screen_reg;

  for (genvar gi = 0; gi < 5; gi++) begin : g_prg_bit
    if (gi < PRG_BANK_BITS) begin : g_used
      assign prg_bank_next[gi] = cap_data_reg[gi];
    end else begin : g_zero
      assign prg_bank_next[gi] = 1'b0;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_chr_bit
    if (gi < CHR_BANK_BITS) begin : g_used
      assign chr_bank_next[gi] = cap_data_reg[5 + gi];
    end else begin : g_zero
      assign chr_bank_next[gi] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prg_bank_reg   <= 5'b00000;
      chr_bank_reg   <= 2'b00;
      one_screen_reg <= 1'b0;
    end else if (bank_wr) begin
      prg_bank_reg   <= prg_bank_next;
      chr_bank_reg   <= chr_bank_next;
      one_screen_reg <= cap_data_reg[7];
    end
  end

  // -------------------------------------------------------------- CPU side
  assign cpu_addr_out[6:2] = cpu_addr_in[14] ? FIXED_PRG_BANK : prg_bank_reg;
  assign cpu_addr_out[1:0] = cpu_addr_in[13:12];
  assign cpu_flash_ce      = romsel;
  assign cpu_rd_out        = ~cpu_rw_in;
  assign cpu_wr_out        = 1'b1;
  assign cpu_sram_ce       = 1'b1;

  // -------------------------------------------------------------- PPU side
  assign ppu_addr_out[8:5] = 4'b0000;
  assign ppu_addr_out[4:3] = chr_bank_reg;
  assign ppu_addr_out[2:0] = ppu_addr_in[2:0];
  assign ppu_sram_ce       = ppu_addr_in[3];
  assign ppu_ciram_ce      = ~ppu_addr_in[3];
  assign ppu_flash_ce      = 1'b1;
  assign ppu_rd_out        = ppu_rd_in;
  assign ppu_wr_out        = ppu_wr_in;

  always_comb begin
    ppu_ciram_a10 = ppu_addr_in[1];
    case (MIRROR_MODE)
      MIRROR_H:   ppu_ciram_a10 = ppu_addr_in[1];
      MIRROR_V:   ppu_ciram_a10 = ppu_addr_in[0];
      MIRROR_ONE: ppu_ciram_a10 = one_screen_reg;
      default:    ppu_ciram_a10 = ppu_addr_in[1];
    endcase
  end

  // ------------------------------------------------------------------- IRQ
  logic irq_pending;

  if (IRQ_ENABLE != 0) begin : g_irq
    cpu_cycle_irq u_irq (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick      (m2_fall),
      .wr_en     (irq_wr),
      .wr_offset (cap_off_reg),
      .wr_data   (cap_data_reg),
      .pending   (irq_pending)
    );
    assign irq = irq_pending ? 1'b0 : 1'bz;
  end else begin : g_no_irq
    assign irq_pending = 1'b0;
    assign irq         = 1'bz;
  end

  assign led = ~irq_pending;

  // Address bits that never reach a decoder, and captures that some
  // parameter choices leave unread.
  logic unused_bits;
  assign unused_bits = ^{cpu_addr_in[11:2], cap_data_reg, irq_wr};

endmodule

// File: tb/tb_uxrom_ext_mapper.sv
module tb_uxrom_ext_mapper;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m2 = 1'b0;
  logic        romsel = 1'b1;
  logic        cpu_rw_in = 1'b1;
  logic [14:0] cpu_addr_in = 15'h0000;
  logic [7:0]  cpu_data_in = 8'h00;
  logic        ppu_rd_in = 1'b1;
  logic        ppu_wr_in = 1'b1;
  logic [3:0]  ppu_addr_in = 4'h0;

  // default-parameter instance
  logic [6:0] cpu_addr_out;
  logic       cpu_wr_out, cpu_rd_out, cpu_flash_ce, cpu_sram_ce;
  logic [8:0] ppu_addr_out;
  logic       ppu_rd_out, ppu_wr_out, ppu_flash_ce, ppu_sram_ce, ppu_ciram_a10, ppu_ciram_ce;
  logic       led;
  wire        irq_w;
  pullup (irq_w);

  // 5-bit PRG, 2-bit CHR, one-screen instance
  logic [6:0] cpu_addr_out_b;
  logic       cpu_wr_out_b, cpu_rd_out_b, cpu_flash_ce_b, cpu_sram_ce_b;
  logic [8:0] ppu_addr_out_b;
  logic       ppu_rd_out_b, ppu_wr_out_b, ppu_flash_ce_b, ppu_sram_ce_b, ppu_ciram_a10_b, ppu_ciram_ce_b;
  logic       led_b;
  wire        irq_w_b;
  pullup (irq_w_b);

  always #5 clk = ~clk;

  uxrom_ext_mapper dut (
    .clk(clk), .rst_n(rst_n), .m2(m2), .romsel(romsel), .cpu_rw_in(cpu_rw_in),
    .cpu_addr_in(cpu_addr_in), .cpu_data_in(cpu_data_in), .cpu_addr_out(cpu_addr_out),
    .cpu_wr_out(cpu_wr_out), .cpu_rd_out(cpu_rd_out), .cpu_flash_ce(cpu_flash_ce),
    .cpu_sram_ce(cpu_sram_ce), .ppu_rd_in(ppu_rd_in), .ppu_wr_in(ppu_wr_in),
    .ppu_addr_in(ppu_addr_in), .ppu_addr_out(ppu_addr_out), .ppu_rd_out(ppu_rd_out),
    .ppu_wr_out(ppu_wr_out), .ppu_flash_ce(ppu_flash_ce), .ppu_sram_ce(ppu_sram_ce),
    .ppu_ciram_a10(ppu_ciram_a10), .ppu_ciram_ce(ppu_ciram_ce), .irq(irq_w), .led(led)
  );

  uxrom_ext_mapper #(
    .PRG_BANK_BITS(5), .CHR_BANK_BITS(2), .MIRROR_MODE(2), .IRQ_ENABLE(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .m2(m2), .romsel(romsel), .cpu_rw_in(cpu_rw_in),
    .cpu_addr_in(cpu_addr_in), .cpu_data_in(cpu_data_in), .cpu_addr_out(cpu_addr_out_b),
    .cpu_wr_out(cpu_wr_out_b), .cpu_rd_out(cpu_rd_out_b), .cpu_flash_ce(cpu_flash_ce_b),
    .cpu_sram_ce(cpu_sram_ce_b), .ppu_rd_in(ppu_rd_in), .ppu_wr_in(ppu_wr_in),
    .ppu_addr_in(ppu_addr_in), .ppu_addr_out(ppu_addr_out_b), .ppu_rd_out(ppu_rd_out_b),
    .ppu_wr_out(ppu_wr_out_b), .ppu_flash_ce(ppu_flash_ce_b), .ppu_sram_ce(ppu_sram_ce_b),
    .ppu_ciram_a10(ppu_ciram_a10_b), .ppu_ciram_ce(ppu_ciram_ce_b), .irq(irq_w_b), .led(led_b)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end else begin
      $display("ok   %s value=%h", nm, act);
    end
  endtask

  // {led, led_b, irq, irq_b}: all low when pending, all high (pulled up) when idle
  task automatic check_irq(input string nm, input logic exp_pend);
    check(nm, {28'h0, led, led_b, irq_w, irq_w_b}, exp_pend ? 32'h0 : 32'hF);
  endtask

  // One CPU cycle of 8 clk: M2 high 4 clk, low 4 clk. Returns after the
  // commit has settled.
  task automatic cpu_cycle(input logic rs, input logic rw, input logic [14:0] a, input logic [7:0] d);
    @(negedge clk);
    romsel = rs; cpu_rw_in = rw; cpu_addr_in = a; cpu_data_in = d; m2 = 1'b1;
    repeat (4) @(negedge clk);
    m2 = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic idle_cycle();
    cpu_cycle(1'b1, 1'b1, 15'h0000, 8'h00);
  endtask

  task automatic irq_write(input logic [1:0] off, input logic [7:0] d);
    cpu_cycle(1'b1, 1'b0, {13'h1400, off}, d);   // $5000 + off
  endtask

  typedef struct {
    string      name;
    logic       do_wr;
    logic [7:0] wdata;
    logic [14:0] addr;
    logic [3:0] ppu_a;
    logic [6:0] cpu1, cpu2;
    logic [8:0] ppu1, ppu2;
    logic       a10_1, a10_2;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int fired;
    logic [3:0] pv;

    vecs[0] = '{"rst_8123",  1'b0, 8'h00, 15'h0123, 4'h0, 7'h00, 7'h00, 9'h000, 9'h000, 1'b0, 1'b0};
    vecs[1] = '{"rst_c000",  1'b0, 8'h00, 15'h4000, 4'h2, 7'h7C, 7'h7C, 9'h002, 9'h002, 1'b1, 1'b0};
    vecs[2] = '{"bank_05",   1'b1, 8'h05, 15'h0123, 4'h9, 7'h14, 7'h14, 9'h001, 9'h001, 1'b0, 1'b0};
    vecs[3] = '{"bank_e3",   1'b1, 8'hE3, 15'h3456, 4'h5, 7'h0F, 7'h0F, 9'h005, 9'h01D, 1'b0, 1'b1};
    vecs[4] = '{"fixed_fff", 1'b0, 8'h00, 15'h7FFF, 4'hE, 7'h7F, 7'h7F, 9'h006, 9'h01E, 1'b1, 1'b1};
    vecs[5] = '{"bank_1f",   1'b1, 8'h1F, 15'h2000, 4'h3, 7'h3E, 7'h7E, 9'h003, 9'h003, 1'b1, 1'b0};
    vecs[6] = '{"bank_40",   1'b1, 8'h40, 15'h1000, 4'h0, 7'h01, 7'h01, 9'h000, 9'h010, 1'b0, 1'b0};
    vecs[7] = '{"bank_80",   1'b1, 8'h80, 15'h0000, 4'hA, 7'h00, 7'h00, 9'h002, 9'h002, 1'b1, 1'b1};

    // reset: 4 clk low
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_irq("reset_irq_idle", 1'b0);

    // banking / mirroring table
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].do_wr) cpu_cycle(1'b0, 1'b0, 15'h0000, vecs[i].wdata);
      @(negedge clk);
      romsel = 1'b0; cpu_rw_in = 1'b1;
      cpu_addr_in = vecs[i].addr; ppu_addr_in = vecs[i].ppu_a;
      #1;
      check({vecs[i].name, "_cpu"},  {18'h0, cpu_addr_out, cpu_addr_out_b},
            {18'h0, vecs[i].cpu1, vecs[i].cpu2});
      check({vecs[i].name, "_ppu"},  {12'h0, ppu_addr_out, ppu_addr_out_b, ppu_ciram_a10, ppu_ciram_a10_b},
            {12'h0, vecs[i].ppu1, vecs[i].ppu2, vecs[i].a10_1, vecs[i].a10_2});
    end

    // one-screen after 0xE3 covers every PPU address; strobes ride along
    cpu_cycle(1'b0, 1'b0, 15'h0000, 8'hE3);
    for (int p = 0; p < 16; p++) begin
      pv = p[3:0];
      @(negedge clk);
      ppu_addr_in = pv; ppu_rd_in = pv[0]; ppu_wr_in = pv[1];
      romsel = pv[2]; cpu_rw_in = pv[3];
      #1;
      check($sformatf("strobes_p%0d", p),
            {21'h0, ppu_ciram_a10_b, ppu_ciram_a10, ppu_sram_ce, ppu_ciram_ce, ppu_rd_out,
             ppu_wr_out, ppu_flash_ce, cpu_flash_ce, cpu_rd_out, cpu_wr_out, cpu_sram_ce},
            {21'h0, 1'b1, pv[1], pv[3], ~pv[3], pv[0], pv[1], 1'b1, pv[2], ~pv[3], 1'b1, 1'b1});
    end

    // write latency: not yet visible 2 clk after the M2 pin falls, visible after 4
    @(negedge clk);
    romsel = 1'b0; cpu_rw_in = 1'b0; cpu_addr_in = 15'h0000; cpu_data_in = 8'hEA; m2 = 1'b1;
    repeat (4) @(negedge clk);
    m2 = 1'b0;
    repeat (2) @(negedge clk);
    check("latency_2clk_old", {18'h0, cpu_addr_out, cpu_addr_out_b}, {18'h0, 7'h0C, 7'h0C});
    repeat (2) @(negedge clk);
    check("latency_4clk_new", {18'h0, cpu_addr_out, cpu_addr_out_b}, {18'h0, 7'h28, 7'h28});
    cpu_rw_in = 1'b1;

    // one-shot IRQ, reload 3: fires on the 4th M2 fall after the enable write
    irq_write(2'd0, 8'h03);
    irq_write(2'd1, 8'h00);
    irq_write(2'd2, 8'h01);
    check_irq("oneshot_after_enable", 1'b0);
    for (int k = 1; k <= 4; k++) begin
      idle_cycle();
      check_irq($sformatf("oneshot_fall%0d", k), k == 4);
    end
    irq_write(2'd3, 8'h00);
    check_irq("oneshot_ack", 1'b0);
    fired = 0;
    for (int k = 0; k < 100; k++) begin
      idle_cycle();
      if (!led || !led_b) fired++;
    end
    check("oneshot_no_refire", fired, 0);

    // auto-reload, reload 2: expiry every 3 falls; ack on an expiry fall loses
    irq_write(2'd0, 8'h02);
    irq_write(2'd2, 8'h03);
    begin
      logic [9:0] ack_at  = 10'b11_0000_1000;   // bit k-1 set: ack on fall k
      logic [9:0] exp_pnd = 10'b01_1110_0100;   // bit k-1 set: pending after fall k
      for (int k = 1; k <= 10; k++) begin
        if (ack_at[k-1]) irq_write(2'd3, 8'h00);
        else idle_cycle();
        check_irq($sformatf("auto_fall%0d", k), exp_pnd[k-1]);
      end
    end
    idle_cycle();   // counter 1 -> 0
    idle_cycle();   // expiry
    check_irq("auto_fire_before_reset", 1'b1);

    // reset in the middle of counting
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_irq("reset_midcount_next_clk", 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    romsel = 1'b0; cpu_rw_in = 1'b1; cpu_addr_in = 15'h0123; ppu_addr_in = 4'h0;
    #1;
    check("reset_banks", {9'h0, cpu_addr_out, cpu_addr_out_b, ppu_addr_out_b, ppu_ciram_a10_b}, 32'h0);
    fired = 0;
    for (int k = 0; k < 20; k++) begin
      idle_cycle();
      if (!led || !led_b) fired++;
    end
    check("reset_no_irq_after_release", fired, 0);

    // reload 0 fires on the first following fall; ctrl write with enable 0 keeps pending
    irq_write(2'd2, 8'h01);
    check_irq("reload0_load", 1'b0);
    idle_cycle();
    check_irq("reload0_fire", 1'b1);
    irq_write(2'd2, 8'h00);
    check_irq("disable_keeps_pending", 1'b1);
    irq_write(2'd3, 8'h00);
    check_irq("disable_ack", 1'b0);
    fired = 0;
    for (int k = 0; k < 10; k++) begin
      idle_cycle();
      if (!led || !led_b) fired++;
    end
    check("disabled_stays_quiet", fired, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
